// File: rtl/avalon_ram_slave.sv
// Avalon-MM RAM responder: word-organised window with byte-lane writes, WAIT_CYCLES wait states and a sticky error flag.
// Optional master-stability checking is compiled in with AVALON_PROTOCOL_CHECK_EN.
module avalon_ram_slave #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'hBFC00000,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic        write,
    input  logic        read,
    output logic        waitrequest,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic [31:0] readdata,
    output logic        error
);
    localparam int unsigned IDX_W        = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  WAIT_LAST    = 4'(WAIT_CYCLES);
    localparam logic [31:0] WINDOW_BYTES = 32'(DEPTH_WORDS * 4);

    logic [3:0]       cnt;
    logic [3:0]       cnt_next;
    logic             req;
    logic             complete;
    logic             access_err;
    logic             protocol_violation;
    logic [31:0]      offset;
    logic [IDX_W-1:0] idx;
    logic [31:0]      mem [DEPTH_WORDS];

    assign req    = read | write;
    // Unsigned subtraction: addresses below BASE_ADDR wrap to huge offsets and fall out of the window.
    assign offset = address - BASE_ADDR;
    assign idx    = offset[IDX_W+1:2];
    assign access_err = (address[1:0] != 2'b00) | (offset >= WINDOW_BYTES) | (read & write);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) cnt <= '0;
        else       cnt <= cnt_next;
    end

    always_comb begin
        cnt_next = '0;
        if (req && waitrequest) cnt_next = cnt + 4'd1;
    end

    always_comb begin
        waitrequest = req && (cnt != WAIT_LAST);
        complete    = req && (cnt == WAIT_LAST);
        readdata    = '0;
        if (complete && read && !access_err) readdata = mem[idx];
    end

    // NOTE: the RAM array is deliberately not reset; its contents survive reset and it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (!reset && complete && write && !access_err) begin
            for (int i = 0; i < 4; i++) begin
                if (byteenable[i]) mem[idx][8*i +: 8] <= writedata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)                                            error <= 1'b0;
        else if ((complete && access_err) || protocol_violation) error <= 1'b1;
    end

`ifdef AVALON_PROTOCOL_CHECK_EN
    logic [31:0] cap_address;
    logic [31:0] cap_writedata;
    logic [3:0]  cap_byteenable;
    logic        cap_read;
    logic        cap_write;
    logic        field_changed;

    // cnt != 0 means the previous edge saw a stalled request, so the master must still be holding it.
    always_ff @(posedge clk) begin
        if (reset) begin
            cap_address    <= '0;
            cap_writedata  <= '0;
            cap_byteenable <= '0;
            cap_read       <= 1'b0;
            cap_write      <= 1'b0;
        end else if (waitrequest && cnt == '0) begin
            cap_address    <= address;
            cap_writedata  <= writedata;
            cap_byteenable <= byteenable;
            cap_read       <= read;
            cap_write      <= write;
        end
    end

    always_comb begin
        field_changed = (address != cap_address) || (writedata != cap_writedata) ||
                        (byteenable != cap_byteenable) || (read != cap_read) || (write != cap_write);
        protocol_violation = 1'b0;
        if (!reset && cnt != '0) protocol_violation = !req || (waitrequest && field_changed);
    end

    always_ff @(posedge clk) begin
        if (protocol_violation) begin
            if (!req)                         $error("%0t: request dropped while waitrequest high", $time);
            if (address != cap_address)       $error("%0t: address changed during wait", $time);
            if (writedata != cap_writedata)   $error("%0t: writedata changed during wait", $time);
            if (byteenable != cap_byteenable) $error("%0t: byteenable changed during wait", $time);
            if (req && (read != cap_read || write != cap_write))
                $error("%0t: read/write changed during wait", $time);
        end
    end
`else
    assign protocol_violation = 1'b0;
`endif

endmodule

// File: doc/avalon_ram_slave.md
Name: avalon_ram_slave

Overview:
- Avalon memory-mapped responder (slave) for the mips_cpu_bus master.
- Word-organised RAM window with byte-lane writes and a programmable number of wait states driven on waitrequest.
- Serves as the memory end of the CPU bus in simulation benches and FPGA bring-up.
- Flags out-of-window, misaligned and illegal accesses on a sticky error output.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words in the window; power of two.
- BASE_ADDR, 32'hBFC00000: byte address of word 0; must be aligned to DEPTH_WORDS*4.
- WAIT_CYCLES, 2: wait-state cycles inserted per transfer; 0..15.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high.
- address  input  32  byte address from master.
- write  input  1  write request.
- read  input  1  read request.
- waitrequest  output  1  stall; master holds all request signals stable while high.
- writedata  input  32  write data.
- byteenable  input  4  lane enables; bit0 = writedata[7:0] … bit3 = writedata[31:24].
- readdata  output  32  read data, valid in the completion cycle.
- error  output  1  sticky access-error flag.

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clk.
- On reset:
  - wait counter cnt = 0; error = 0.
  - Outputs settle to waitrequest = 0, readdata = 0.
  - RAM contents are NOT cleared.
  - A transfer in progress is abandoned; a pending write is not committed.
- req = read | write.
- Wait states: waitrequest = req && (cnt != WAIT_CYCLES), combinational.
- Counter:
  - On each posedge with req=1 and waitrequest=1, cnt increments.
  - On the completion posedge (req=1, waitrequest=0), cnt returns to 0.
  - If req is 0 on any posedge, cnt returns to 0; an aborted transfer has no side effects.
- States (encoded by cnt): IDLE (cnt=0, no req) -> WAIT (counting) -> COMPLETE (cnt==WAIT_CYCLES with req) -> IDLE.
- Latency: completion occurs WAIT_CYCLES cycles after req first asserts. WAIT_CYCLES=0 gives same-cycle completion.
- Back-to-back: a new req in the cycle after completion starts a fresh count from 0.
- Word index: idx = (address - BASE_ADDR) >> 2. In-window iff address - BASE_ADDR < DEPTH_WORDS*4 (unsigned compare; wrap-around below BASE_ADDR is out-of-window).
- Read completion:
  - readdata = mem[idx] combinationally, full word regardless of byteenable.
  - readdata = 0 in every other cycle.
- Write completion: at the completion posedge, each lane i with byteenable[i]=1 updates mem[idx] byte i; other lanes are kept.
- Write with byteenable = 0: completes normally, no memory change.
- Errors: set error at the completion posedge, with the access suppressed (no write, readdata = 0), when any of these hold:
  - address[1:0] != 0;
  - address is out-of-window;
  - read and write are both 1.
- Errored accesses still complete with normal wait timing, so the master never hangs.
- error stays 1 until reset.
- Read-after-write to the same word in the next transfer returns the new data.

Optional Feature:
- Macro: AVALON_PROTOCOL_CHECK_EN.
- With the macro defined:
  - At the first wait cycle, capture address, read, write, writedata and byteenable.
  - On each later cycle with waitrequest=1, compare them against the capture.
  - Any mismatch sets error (sticky) and issues $error with the time and offending field.
  - req dropping while waitrequest=1 is also a violation.
- Without the macro: no capture registers; such master misbehaviour is silently treated as an abort or new request per the counter rules.

Test Plan:
- WAIT_CYCLES=2, read at 0xBFC00000 with mem[0]=0x3C021234 -> waitrequest high 2 cycles, low in the 3rd; readdata=0x3C021234 only in that cycle.
- Write 0xAABBCCDD to 0xBFC00008 with byteenable=4'b0101 over a word holding 0x11223344, then read it -> 0x11BB33DD.
- WAIT_CYCLES=0, back-to-back reads of 0xBFC00000 and 0xBFC00004 -> waitrequest never asserts; readdata is correct in each cycle.
- Read at 0xBFC00002, then a read at 0x00000000 -> both complete after WAIT_CYCLES with readdata=0; error=1 and stays set until reset.
- Write asserted, reset pulsed at wait cycle 1 -> waitrequest=0 after reset; target word unchanged; error=0.
- AVALON_PROTOCOL_CHECK_EN defined, address changed from 0xBFC00010 to 0xBFC00014 mid-wait -> error=1 and $error reported; without the macro, error stays 0.
